mem_burst_master: RTL and testbench

- Initiator for the 256x32 single-port synchronous memory (write on clk edge when we=1, read data valid one clock after address is presented).
- Accepts one burst command at a time: a write burst (stream in -> memory) or a read burst (memory -> stream out), with valid/ready handshakes on both streams.
- Replaces bench-side hierarchical loading of memory contents. Sits between stream producers/consumers and the memory macro.

---
 rtl/mem_burst_if.sv | 37 +++
 rtl/mem_burst_master.sv | 164 ++++++++++++++++
 tb/tb_mem_burst_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_if.sv
// Bundle of command, write-stream, read-stream and memory-port signals for mem_burst_master.
// The master modport is the burst engine's view; slave is the surrounding environment's view.
interface mem_burst_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          verify_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, mem_rdata,
        output cmd_ready, wr_ready, rd_data, rd_valid, rd_last, busy, mem_addr, mem_we, mem_wdata,
               verify_err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, mem_rdata,
        input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last, busy, mem_addr, mem_we, mem_wdata,
               verify_err
    );
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port synchronous memory with 1-cycle read latency.
// Define MEM_BURST_VERIFY_EN to add a readback-verify pass after every write burst.
module mem_burst_master #(
    parameter int DW         = 32,
    parameter int AW         = 8,
    parameter int FIFO_DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    mem_burst_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef MEM_BURST_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, VERIFY} state_t;
    logic [AW-1:0] start, len_q, inflight_off;
    logic [DW-1:0] shadow [2**AW];
    logic          verr;
`else
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN} state_t;
`endif

    state_t        state, state_nxt;
    logic [AW-1:0] cur, remaining;
    logic          inflight, inflight_last, inflight_vfy;
    logic [DW-1:0] fifo_data [FIFO_DEPTH];
    logic          fifo_last [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          cmd_fire, wr_fire, issue, push, pop;
    int            occ;

    assign push          = inflight && !inflight_vfy;
    assign bus.rd_valid  = (count != '0) && !rst;
    assign bus.rd_data   = fifo_data[rd_ptr];
    assign bus.rd_last   = fifo_last[rd_ptr] && bus.rd_valid;
    assign pop           = bus.rd_valid && bus.rd_ready;
    assign bus.busy      = (state != IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Outputs are gated by rst so an abort takes effect in the reset cycle itself.
    always_comb begin
        state_nxt     = state;
        cmd_fire      = 1'b0;
        wr_fire       = 1'b0;
        issue         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        // Credit a same-cycle pop so a continuous read stream sustains one word per clock.
        occ = int'(count) + int'(push) - int'(pop);
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    bus.cmd_ready = 1'b1;
                    if (bus.cmd_valid) begin
                        cmd_fire  = 1'b1;
                        state_nxt = bus.cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    bus.wr_ready = 1'b1;
                    if (bus.wr_valid) begin
                        wr_fire       = 1'b1;
                        bus.mem_we    = 1'b1;
                        bus.mem_addr  = cur;
                        bus.mem_wdata = bus.wr_data;
`ifdef MEM_BURST_VERIFY_EN
                        if (remaining == '0) state_nxt = VERIFY;
`else
                        if (remaining == '0) state_nxt = IDLE;
`endif
                    end
                end
                READ: begin
                    if (occ < FIFO_DEPTH) begin
                        issue        = 1'b1;
                        bus.mem_addr = cur;
                        if (remaining == '0) state_nxt = DRAIN;
                    end
                end
`ifdef MEM_BURST_VERIFY_EN
                VERIFY: begin
                    issue        = 1'b1;
                    bus.mem_addr = cur;
                    if (remaining == '0) state_nxt = DRAIN;
                end
`endif
                DRAIN: begin
                    if (count == '0 && !inflight) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur           <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (remaining == '0);
            if (cmd_fire) begin
                cur       <= bus.cmd_addr;
                remaining <= bus.cmd_len;
            end else if (wr_fire || issue) begin
                cur       <= cur + 1'b1;
                remaining <= remaining - 1'b1;
`ifdef MEM_BURST_VERIFY_EN
                if (wr_fire && remaining == '0) begin
                    cur       <= start;
                    remaining <= len_q;
                end
`endif
            end
            if (push) begin
                fifo_data[wr_ptr] <= bus.mem_rdata;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef MEM_BURST_VERIFY_EN
    // Shadow is indexed by offset from the burst start so verify compares in write order.
    always_ff @(posedge clk) begin
        if (wr_fire) shadow[cur - start] <= bus.wr_data;
        if (rst) begin
            start        <= '0;
            len_q        <= '0;
            inflight_off <= '0;
            inflight_vfy <= 1'b0;
            verr         <= 1'b0;
        end else begin
            if (cmd_fire) begin
                start <= bus.cmd_addr;
                len_q <= bus.cmd_len;
            end
            inflight_vfy <= issue && (state == VERIFY);
            inflight_off <= cur - start;
            if (inflight && inflight_vfy && bus.mem_rdata != shadow[inflight_off]) verr <= 1'b1;
        end
    end
    assign bus.verify_err = verr;
`else
    assign inflight_vfy   = 1'b0;
    assign bus.verify_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_burst_master.sv
// Randomized self-checking bench for mem_burst_master with a behavioural memory and a
// reference image of memory contents maintained from the stream traffic the bench sends.
module tb_mem_burst_master;
    logic clk, rst;
    int   cyc = 0;
    int   vectors = 0, miscompares = 0, tmo_cnt = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] wq [$];
    logic        corrupt_on = 1'b0;
    logic [7:0]  corrupt_addr = 8'h00;

    mem_burst_if #(.DW(32), .AW(8)) b ();
    mem_burst_master #(.DW(32), .AW(8), .FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(b));

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro model; corrupt_on flips bit 0 of one row as it is written.
    always @(posedge clk) begin
        if (b.mem_we)
            mem[b.mem_addr] <= b.mem_wdata ^ ((corrupt_on && b.mem_addr == corrupt_addr) ? 32'h1 : 32'h0);
        b.mem_rdata <= mem[b.mem_addr];
    end

    // All drivers enter and leave 1 time unit after a rising edge.
    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] l, output int acc);
        int t = 0;
        b.cmd_valid = 1'b1; b.cmd_write = w; b.cmd_addr = a; b.cmd_len = l; #1;
        while (b.cmd_ready !== 1'b1 && t < 2000) begin @(posedge clk); #2; t++; end
        if (t >= 2000) tmo_cnt++;
        acc = cyc;
        @(posedge clk); #1;
        b.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        #1;
        while (b.cmd_ready !== 1'b1 && t < 2000) begin @(posedge clk); #2; t++; end
        if (t >= 2000) tmo_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic write_data(input logic [7:0] a, input int n, input int gap, output int bad);
        int t;
        logic [7:0] ea;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            ea = a + 8'(i);
            for (int g = 0; g < gap; g++) begin
                b.wr_valid = 1'b0; #1;
                if (b.mem_we !== 1'b0) bad++;
                @(posedge clk); #1;
            end
            b.wr_valid = 1'b1; b.wr_data = wq[i]; #1; t = 0;
            while (b.wr_ready !== 1'b1 && t < 100) begin @(posedge clk); #2; t++; end
            if (t >= 100) tmo_cnt++;
            if (b.mem_we !== 1'b1 || b.mem_addr !== ea || b.mem_wdata !== wq[i]) bad++;
            ref_mem[ea] = wq[i];
            @(posedge clk); #1;
        end
        b.wr_valid = 1'b0;
    endtask

    // mode 0: rd_ready always high, 1: toggling 1-0-1-0, 2: random
    task automatic read_burst(input logic [7:0] a, input logic [7:0] l, input int mode,
                              output int got, output int errs, output int lat, output int span);
        int acc, t, first;
        logic stall, rdy;
        logic [31:0] held;
        logic [7:0] ea;
        send_cmd(1'b0, a, l, acc);
        got = 0; errs = 0; lat = -1; span = -1; t = 0; stall = 1'b0; held = '0; first = 0;
        while (got <= int'(l) && t < 3000) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
            b.rd_ready = rdy; #1;
            if (b.rd_valid === 1'b1 && lat < 0) lat = cyc - acc;
            if (stall && (b.rd_valid !== 1'b1 || b.rd_data !== held)) errs++;
            if (b.rd_valid === 1'b1 && rdy) begin
                ea = a + 8'(got);
                if (b.rd_data !== ref_mem[ea] || b.rd_last !== (got == int'(l))) errs++;
                if (got == 0) first = cyc;
                if (got == int'(l)) span = cyc - first;
                got++;
            end
            stall = (b.rd_valid === 1'b1) && !rdy;
            held  = b.rd_data;
            @(posedge clk); #1; t++;
        end
        b.rd_ready = 1'b0;
        if (t >= 3000) tmo_cnt++;
        wait_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b.cmd_valid = 1'b0; b.cmd_write = 1'b0; b.cmd_addr = '0; b.cmd_len = '0;
        b.wr_valid = 1'b0; b.wr_data = '0; b.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++; if (b.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 0", b.cmd_ready); end
        vectors++; if (b.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", b.busy); end
        vectors++; if (b.wr_ready !== 1'b0) begin miscompares++; $display("FAIL reset_wr_ready: got %b want 0", b.wr_ready); end
        vectors++; if (b.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", b.rd_valid); end
        vectors++; if (b.rd_last !== 1'b0) begin miscompares++; $display("FAIL reset_rd_last: got %b want 0", b.rd_last); end
        vectors++; if (b.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", b.mem_we); end
        vectors++; if (b.mem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 00", b.mem_addr); end
        vectors++; if (b.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h want 0", b.mem_wdata); end
        vectors++; if (b.verify_err !== 1'b0) begin miscompares++; $display("FAIL reset_verify_err: got %b want 0", b.verify_err); end
        @(posedge clk); #1; rst = 1'b0; #1;
        vectors++; if (b.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL idle_cmd_ready: got %b want 1", b.cmd_ready); end
        vectors++; if (b.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", b.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int acc, bad, got, errs, lat, span;
        wq.delete(); wq.push_back(32'hABCDEF00);
        send_cmd(1'b1, 8'h0F, 8'h00, acc);
        write_data(8'h0F, 1, 0, bad);
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL single_write: %0d bad handshakes, want 0", bad); end
        wait_idle();
        vectors++; if (mem[8'h0F] !== 32'hABCDEF00) begin miscompares++; $display("FAIL single_mem: got %h want abcdef00", mem[8'h0F]); end
        read_burst(8'h0F, 8'h00, 0, got, errs, lat, span);
        vectors++; if (got != 1 || errs != 0) begin miscompares++; $display("FAIL single_read: got %0d words %0d errs, want 1/0", got, errs); end
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL single_latency: got %0d want 3", lat); end
    endtask

    task automatic test_full_write();
        int acc, bad, c0, errs;
        logic [7:0] a;
        a = 8'($urandom);
        wq.delete(); for (int i = 0; i < 256; i++) wq.push_back($urandom);
        send_cmd(1'b1, a, 8'hFF, acc);
        c0 = cyc;
        write_data(a, 256, 0, bad);
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL full_write: %0d bad handshakes, want 0", bad); end
        vectors++; if (cyc - c0 != 256) begin miscompares++; $display("FAIL full_write_rate: got %0d clks want 256", cyc - c0); end
        errs = 0;
        for (int r = 0; r < 256; r++) if (mem[r] !== ref_mem[r]) errs++;
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL full_write_mem: %0d rows wrong, want 0", errs); end
        wait_idle();
    endtask

    task automatic test_wrap();
        int acc, bad, got, errs, lat, span;
        wq.delete(); wq.push_back(32'h11); wq.push_back(32'h22); wq.push_back(32'h33);
        send_cmd(1'b1, 8'hFE, 8'h02, acc);
        write_data(8'hFE, 3, 0, bad);
        wait_idle();
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL wrap_write: %0d bad handshakes, want 0", bad); end
        vectors++;
        if (mem[8'hFE] !== 32'h11 || mem[8'hFF] !== 32'h22 || mem[8'h00] !== 32'h33) begin
            miscompares++;
            $display("FAIL wrap_mem: got %h %h %h want 11 22 33", mem[8'hFE], mem[8'hFF], mem[8'h00]);
        end
        read_burst(8'hFE, 8'h02, 0, got, errs, lat, span);
        vectors++; if (got != 3 || errs != 0) begin miscompares++; $display("FAIL wrap_read: got %0d words %0d errs, want 3/0", got, errs); end
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL wrap_latency: got %0d want 3", lat); end
        vectors++; if (span != 2) begin miscompares++; $display("FAIL wrap_rate: got %0d clks want 2", span); end
    endtask

    task automatic test_read_stall();
        int got, errs, lat, span;
        read_burst(8'($urandom), 8'hFF, 1, got, errs, lat, span);
        vectors++; if (got != 256) begin miscompares++; $display("FAIL stall_count: got %0d want 256", got); end
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL stall_data: %0d errs want 0", errs); end
        read_burst(8'h00, 8'hFF, 0, got, errs, lat, span);
        vectors++; if (got != 256 || errs != 0) begin miscompares++; $display("FAIL stream_read: got %0d words %0d errs, want 256/0", got, errs); end
        vectors++; if (span != 255) begin miscompares++; $display("FAIL stream_rate: got %0d clks want 255", span); end
    endtask

    task automatic test_gap_write();
        int acc, bad, errs;
        logic [7:0] ea;
        wq.delete(); for (int i = 0; i < 6; i++) wq.push_back($urandom);
        send_cmd(1'b1, 8'h80, 8'h05, acc);
        write_data(8'h80, 6, 2, bad);
        wait_idle();
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL gap_write_we: %0d bad cycles, want 0", bad); end
        errs = 0;
        for (int i = 0; i < 6; i++) begin ea = 8'h80 + 8'(i); if (mem[ea] !== wq[i]) errs++; end
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL gap_write_mem: %0d rows wrong, want 0", errs); end
    endtask

    task automatic test_random();
        int acc, bad, got, errs, lat, span;
        logic [7:0] a, l, ea;
        for (int k = 0; k < 10; k++) begin
            a = 8'($urandom);
            l = 8'($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1) begin
                wq.delete(); for (int i = 0; i <= int'(l); i++) wq.push_back($urandom);
                send_cmd(1'b1, a, l, acc);
                write_data(a, int'(l) + 1, int'($urandom_range(0, 2)), bad);
                wait_idle();
                vectors++; if (bad != 0) begin miscompares++; $display("FAIL rand_write: burst %0d %0d bad, want 0", k, bad); end
                errs = 0;
                for (int i = 0; i <= int'(l); i++) begin ea = a + 8'(i); if (mem[ea] !== ref_mem[ea]) errs++; end
                vectors++; if (errs != 0) begin miscompares++; $display("FAIL rand_write_mem: burst %0d %0d rows wrong, want 0", k, errs); end
            end else begin
                read_burst(a, l, 2, got, errs, lat, span);
                vectors++;
                if (got != int'(l) + 1 || errs != 0) begin
                    miscompares++;
                    $display("FAIL rand_read: burst %0d got %0d words %0d errs, want %0d/0", k, got, errs, int'(l) + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc, bad, errs;
        wq.delete(); for (int i = 0; i < 10; i++) wq.push_back($urandom);
        send_cmd(1'b1, 8'h00, 8'h09, acc);
        write_data(8'h00, 5, 0, bad);
        rst = 1'b1; b.wr_valid = 1'b1; b.wr_data = wq[5]; #1;
        vectors++; if (b.mem_we !== 1'b0) begin miscompares++; $display("FAIL abort_mem_we: got %b want 0", b.mem_we); end
        vectors++; if (b.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", b.busy); end
        @(posedge clk); #1; rst = 1'b0; b.wr_valid = 1'b0; #1;
        vectors++; if (b.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL abort_cmd_ready: got %b want 1", b.cmd_ready); end
        vectors++; if (b.busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle_busy: got %b want 0", b.busy); end
        @(posedge clk); #1;
        errs = 0;
        for (int r = 0; r < 10; r++) if (mem[r] !== ref_mem[r]) errs++;
        vectors++; if (errs != 0 || bad != 0) begin miscompares++; $display("FAIL abort_rows: %0d rows wrong %0d bad, want 0/0", errs, bad); end
    endtask

`ifdef MEM_BURST_VERIFY_EN
    task automatic test_verify();
        int acc, bad;
        wq.delete(); for (int i = 0; i < 4; i++) wq.push_back($urandom);
        send_cmd(1'b1, 8'h20, 8'h03, acc); write_data(8'h20, 4, 0, bad); wait_idle();
        vectors++; if (b.verify_err !== 1'b0) begin miscompares++; $display("FAIL verify_clean: got %b want 0", b.verify_err); end
        corrupt_on = 1'b1; corrupt_addr = 8'h30;
        wq.delete(); wq.push_back(32'hFBE0015A);
        send_cmd(1'b1, 8'h30, 8'h00, acc); write_data(8'h30, 1, 0, bad);
        corrupt_on = 1'b0;
        wait_idle();
        vectors++; if (b.verify_err !== 1'b1) begin miscompares++; $display("FAIL verify_corrupt: got %b want 1", b.verify_err); end
        wq.delete(); wq.push_back($urandom);
        send_cmd(1'b1, 8'h40, 8'h00, acc); write_data(8'h40, 1, 0, bad); wait_idle();
        vectors++; if (b.verify_err !== 1'b1) begin miscompares++; $display("FAIL verify_sticky: got %b want 1", b.verify_err); end
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; #1;
        vectors++; if (b.verify_err !== 1'b0) begin miscompares++; $display("FAIL verify_cleared: got %b want 0", b.verify_err); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full_write();
        test_wrap();
        test_read_stall();
        test_gap_write();
        test_random();
        test_reset_mid();
`ifdef MEM_BURST_VERIFY_EN
        test_verify();
`endif
        vectors++;
        if (tmo_cnt != 0) begin miscompares++; $display("FAIL handshake_timeouts: got %0d want 0", tmo_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
